// File: rtl/param_multimode_ff_bank_if.sv
// Signal bundle for param_multimode_ff_bank: mode/data/enable controls in, state and status out.
// q_par and par_err are present only when FF_BANK_PARITY_EN is defined.
interface param_multimode_ff_bank_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] en;
  logic             clr;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] changed;
  logic             sr_err;
`ifdef FF_BANK_PARITY_EN
  logic             q_par;
  logic             par_err;
`endif

  // No valid/ready handshake: every input is sampled on every rising clk edge,
  // and outputs are valid from just after that edge until the next one.
  modport master (
    output mode, a, b, en, clr, err_clr,
`ifdef FF_BANK_PARITY_EN
    input  q_par, par_err,
`endif
    input  q, qbar, changed, sr_err
  );

  modport slave (
    input  mode, a, b, en, clr, err_clr,
`ifdef FF_BANK_PARITY_EN
    output q_par, par_err,
`endif
    output q, qbar, changed, sr_err
  );
endinterface

// File: rtl/param_multimode_ff_bank.sv
// WIDTH-bit flip-flop bank with runtime D/T/JK/SR mode, per-bit enables, sync clear,
// change-detect pulses and sticky SR-illegal flag. Optional parity via FF_BANK_PARITY_EN.
module param_multimode_ff_bank #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic                      clk,
  input logic                      rstn,
  param_multimode_ff_bank_if.slave bus
);
  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] changed_r;
  logic             sr_err_r;
  logic             sr_illegal;

  always_comb begin
    q_next     = q_r;
    sr_illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.clr) begin
        q_next[i] = CLEAR_VALUE[i];
      end else if (bus.en[i]) begin
        case (bus.mode)
          MODE_D:  q_next[i] = bus.a[i];
          MODE_T:  q_next[i] = q_r[i] ^ bus.a[i];
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              2'b11:   q_next[i] = ~q_r[i];
              default: q_next[i] = q_r[i];
            endcase
          end
          MODE_SR: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              // S=R=1 holds the bit and raises the sticky error
              2'b11:   sr_illegal = 1'b1;
              default: q_next[i] = q_r[i];
            endcase
          end
          default: q_next[i] = q_r[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r       <= RESET_VALUE;
      changed_r <= '0;
      sr_err_r  <= 1'b0;
    end else begin
      q_r       <= q_next;
      changed_r <= q_next ^ q_r;
      // a new illegal event beats a simultaneous err_clr
      if (sr_illegal)       sr_err_r <= 1'b1;
      else if (bus.err_clr) sr_err_r <= 1'b0;
    end
  end

  assign bus.q       = q_r;
  assign bus.qbar    = ~q_r;
  assign bus.changed = changed_r;
  assign bus.sr_err  = sr_err_r;

`ifdef FF_BANK_PARITY_EN
  logic q_par_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_par_r <= ^RESET_VALUE;
    else       q_par_r <= ^q_next;
  end

  assign bus.q_par   = q_par_r;
  assign bus.par_err = q_par_r ^ (^q_r);
`endif
endmodule

// File: tb/tb_param_multimode_ff_bank.sv
// Directed vector bench for param_multimode_ff_bank (WIDTH=4, RESET_VALUE=0, CLEAR_VALUE=1010).
module tb_param_multimode_ff_bank;
  localparam int W = 4;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] en;
    logic         clr;
    logic         err_clr;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_ch;
    logic         exp_err;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] exp_q[$];
  vec_t vecs[17];

  param_multimode_ff_bank_if #(.WIDTH(W)) bus();

  param_multimode_ff_bank #(
    .WIDTH(W),
    .RESET_VALUE(4'b0000),
    .CLEAR_VALUE(4'b1010)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] en, input logic clr, input logic err_clr);
    bus.mode    = mode;
    bus.a       = a;
    bus.b       = b;
    bus.en      = en;
    bus.clr     = clr;
    bus.err_clr = err_clr;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic [W-1:0] ech,
                           input logic eerr);
    check({tag, " q"}, bus.q, eq);
    check({tag, " qbar"}, bus.qbar, ~eq);
    check({tag, " changed"}, bus.changed, ech);
    check({tag, " sr_err"}, {3'b000, bus.sr_err}, {3'b000, eerr});
`ifdef FF_BANK_PARITY_EN
    check({tag, " q_par"}, {3'b000, bus.q_par}, {3'b000, ^eq});
    check({tag, " par_err"}, {3'b000, bus.par_err}, 4'b0000);
`endif
  endtask

  initial begin
    logic [W-1:0] e;
    n_checks = 0;
    n_errors = 0;
    //              mode   a        b        en       clr   eclr  q        changed  err
    vecs[0]  = '{2'b00, 4'b0110, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0};
    vecs[1]  = '{2'b00, 4'b0110, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0};
    vecs[2]  = '{2'b01, 4'b0011, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b0111, 4'b0001, 1'b0};
    vecs[3]  = '{2'b10, 4'b1100, 4'b0101, 4'b1111, 1'b0, 1'b0, 4'b1010, 4'b1101, 1'b0};
    vecs[4]  = '{2'b11, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b1};
    vecs[5]  = '{2'b11, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b1010, 4'b0000, 1'b1};
    vecs[6]  = '{2'b11, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b1010, 4'b0000, 1'b0};
    vecs[7]  = '{2'b00, 4'b0101, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0};
    vecs[8]  = '{2'b01, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0};
    vecs[9]  = '{2'b01, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1010, 4'b0000, 1'b0};
    vecs[10] = '{2'b11, 4'b0011, 4'b0010, 4'b1111, 1'b0, 1'b0, 4'b1011, 4'b0001, 1'b1};
    vecs[11] = '{2'b11, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1010, 4'b0001, 1'b1};
    vecs[12] = '{2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1010, 4'b0000, 1'b0};
    vecs[13] = '{2'b11, 4'b0001, 4'b0001, 4'b1110, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0};
    vecs[14] = '{2'b10, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0};
    vecs[15] = '{2'b01, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b1101, 4'b1000, 1'b0};
    vecs[16] = '{2'b00, 4'b1101, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b0};
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_q);

    drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].clr, vecs[i].err_clr);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_all($sformatf("vec%0d", i), e, vecs[i].exp_ch, vecs[i].exp_err);
    end

    // load 1111, set sr_err, then reset asynchronously mid-cycle
    @(negedge clk);
    drive(2'b00, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("load_ones", 4'b1111, 4'b0010, 1'b0);
    @(negedge clk);
    drive(2'b11, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("set_err", 4'b1111, 4'b0000, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    drive(2'b00, 4'b0011, 4'b0000, 4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("post_reset_edge", 4'b0011, 4'b0011, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
